event_gen: RTL and testbench
============================

# event_gen

Programmable event-stream generator that drives the `En`/`Slt` pulse interface consumed by the two-channel event counter. On a `Start` command it latches a channel-0 event count and a channel-1 count, then emits single-cycle `En` pulses: first all channel-0 events (`Slt=0`), then `DIV` pulses per requested channel-1 event (`Slt=1`), with a programmable idle gap between pulses. It is the stimulus and producer side of the counter and signals completion with a one-cycle `Done`.

## Interface
- `CW`, 32: width of `Cnt0`/`Cnt1` request counts.
- `GW`, 8: width of `Gap`.
- `DIV`, 4: `Slt=1` pulses emitted per requested channel-1 event; must be ≥1. Matches the counter's prescale.
- `Clk` in 1: single clock, rising edge.
- `Reset` in 1: asynchronous, active-low reset.
- `Start` in 1: command strobe; accepted only when `Busy=0`.
- `Cnt0` in CW: number of channel-0 events, sampled with accepted `Start`.
- `Cnt1` in CW: number of channel-1 events, sampled with accepted `Start`.
- `Gap` in GW: idle cycles between consecutive pulses, sampled with accepted `Start`.
- `En` out 1: event pulse, high for exactly one cycle per event.
- `Slt` out 1: channel select; meaningful only when `En=1`, forced to 0 otherwise.
- `Busy` out 1: high while a command is in progress.
- `Done` out 1: one-cycle completion pulse.

## Operation
- FSM states: IDLE, PULSE, GAP, DONE.
- Accepted `Start` latches `Cnt0`, `Cnt1` and `Gap`. Channel-1 pulse total is `Cnt1*DIV`, held in an internal counter of width CW+$clog2(DIV)+1, so there is no overflow.
- Total pulses N = `Cnt0 + DIV*Cnt1`. If N=0, go directly to DONE.
- PULSE: `En=1`. `Slt=0` while channel-0 pulses remain, else `Slt=1`. Decrement the active remaining count. If this was the last pulse, go to DONE. Else, if Gap=0, stay in PULSE; otherwise go to GAP.
- GAP: `En=0` for exactly Gap cycles, then PULSE. No gap follows the last pulse.
- DONE: `Done=1` for one cycle, `Busy=0`, then IDLE. A `Start` in the DONE cycle is accepted.
- `Start` while `Busy=1` is ignored, and the latched values are unchanged.
- Reset while active aborts immediately. No `Done` is produced and the remaining counts are discarded.

## Timing
- Reset values: `En=0`, `Slt=0`, `Busy=0`, `Done=0`, state IDLE, all counters 0.
- All outputs are registered.
- `Start` accepted at cycle T:
  - `Busy` goes high at T+1.
  - Pulse k (0-based) is emitted at T+1+k·(Gap+1).
  - Last pulse is at T+1+(N−1)(Gap+1).
  - `Done` (with `Busy=0`) is at the cycle after the last pulse.
- If N=0: `Done` at T+1 and `Busy` stays 0.
- Channel-0 pulses always precede channel-1 pulses. The Gap spacing also applies across the channel-0 to channel-1 boundary.

## Configuration
- `EVENT_GEN_PAUSE_EN` defined:
  - Adds input port `Pause` (1 bit).
  - While `Pause=1` in PULSE or GAP: `En=0`, all counters and the state freeze, and `Busy` stays 1.
  - A pulse due in a paused cycle is emitted in the first cycle after `Pause` falls.
  - `Pause` has no effect in IDLE/DONE.
- Undefined: no `Pause` port; behaviour as above with no stalls.

## Structure
- Package `event_gen_pkg` holds:
  - the state enum type;
  - default constants for CW, GW and DIV;
  - the helper width constant for the channel-1 pulse counter.
- Sub-module `event_gap_timer`: a loadable down-counter of width GW, with `load`/`tick`/`expired` signals. It is instantiated once for the GAP state.

## Test plan
- Cnt0=3, Cnt1=0, Gap=0, Start at T → `En` high T+1..T+3, `Slt=0`, `Done` at T+4.
- Cnt0=0, Cnt1=2, Gap=1 → 8 pulses at T+1, T+3, …, T+15, all `Slt=1`, `Done` at T+16; the connected counter reads Output0=0, Output1=2.
- Cnt0=2, Cnt1=1, Gap=2 → pulses at T+1 and T+4 with `Slt=0`, then T+7, T+10, T+13, T+16 with `Slt=1`; `Done` at T+17.
- Cnt0=0, Cnt1=0 → `Done` at T+1, no `En`; a second `Start` during `Busy` of a Cnt0=5 run is ignored, giving exactly 5 pulses.
- Reset asserted mid-run after 2 of 6 pulses → outputs 0 immediately, no `Done`, IDLE; a new Start with Cnt0=1 pulses at T'+1.
- With `EVENT_GEN_PAUSE_EN`: Cnt0=3, Gap=0, `Pause` high at T+2..T+4 → pulses at T+1, T+5, T+6; `Done` at T+7.

Source files
------------

// File: rtl/event_gen_pkg.sv
// Shared types and default sizing for the event_gen block.
package event_gen_pkg;

    typedef enum logic [1:0] {IDLE, PULSE, GAP, DONE} state_e;

    localparam int CW_DEF  = 32;
    localparam int GW_DEF  = 8;
    localparam int DIV_DEF = 4;

    // The channel-1 pulse total is Cnt1*DIV; this width holds it without overflow.
    function automatic int c1_width(input int cw, input int div);
        return cw + $clog2(div) + 1;
    endfunction

    localparam int C1W_DEF = c1_width(CW_DEF, DIV_DEF);

endpackage

// File: rtl/event_gap_timer.sv
// Loadable down-counter that times the idle gap between pulses.
module event_gap_timer
    import event_gen_pkg::*;
#(
    parameter int GW = GW_DEF
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          load_i,
    input  logic [GW-1:0] load_val_i,
    input  logic          tick_i,
    output logic          expired_o
);

    logic [GW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = load_val_i;
        else if (tick_i && cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    // Expired in the last gap cycle so the next pulse lands right after it.
    assign expired_o = (cnt_q <= GW'(1));

endmodule

// File: rtl/event_gen.sv
// Programmable En/Slt event-stream generator for the two-channel counter.
// Define EVENT_GEN_PAUSE_EN to add a Pause input that stalls PULSE/GAP.
module event_gen
    import event_gen_pkg::*;
#(
    parameter int CW  = CW_DEF,
    parameter int GW  = GW_DEF,
    parameter int DIV = DIV_DEF
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic [CW-1:0] Cnt0,
    input  logic [CW-1:0] Cnt1,
    input  logic [GW-1:0] Gap,
`ifdef EVENT_GEN_PAUSE_EN
    input  logic          Pause,
`endif
    output logic          En,
    output logic          Slt,
    output logic          Busy,
    output logic          Done
);

    localparam int C1W = c1_width(CW, DIV);

    state_e         state_q, state_d;
    logic [CW-1:0]  rem0_q, rem0_d;
    logic [C1W-1:0] rem1_q, rem1_d;
    logic [GW-1:0]  gap_q, gap_d;
    logic           en_q, en_d, slt_q, slt_d, busy_q, busy_d, done_q, done_d;
    logic           stall, last, tmr_load, tmr_tick, tmr_exp;

`ifdef EVENT_GEN_PAUSE_EN
    assign stall = Pause;
`else
    assign stall = 1'b0;
`endif

    assign last = (rem0_q == CW'(1) && rem1_q == '0) ||
                  (rem0_q == '0 && rem1_q == C1W'(1));

    always_comb begin
        state_d  = state_q;
        rem0_d   = rem0_q;
        rem1_d   = rem1_q;
        gap_d    = gap_q;
        tmr_load = 1'b0;
        tmr_tick = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (Start) begin
                    rem0_d  = Cnt0;
                    rem1_d  = C1W'(Cnt1) * C1W'(DIV);
                    gap_d   = Gap;
                    state_d = (Cnt0 == '0 && Cnt1 == '0) ? DONE : PULSE;
                end
            end
            PULSE: if (!stall) begin
                if (rem0_q != '0) rem0_d = rem0_q - 1'b1;
                else              rem1_d = rem1_q - 1'b1;
                if (last) begin
                    state_d = DONE;
                end else if (gap_q != '0) begin
                    state_d  = GAP;
                    tmr_load = 1'b1;
                end
            end
            GAP: if (!stall) begin
                if (tmr_exp) state_d  = PULSE;
                else         tmr_tick = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next state, so they line up with it.
        en_d   = (state_d == PULSE);
        slt_d  = en_d && (rem0_d == '0);
        busy_d = (state_d == PULSE) || (state_d == GAP);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            rem0_q  <= '0;
            rem1_q  <= '0;
            gap_q   <= '0;
            en_q    <= 1'b0;
            slt_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem0_q  <= rem0_d;
            rem1_q  <= rem1_d;
            gap_q   <= gap_d;
            en_q    <= en_d;
            slt_q   <= slt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    event_gap_timer #(.GW(GW)) u_gap (
        .Clk        (Clk),
        .Reset      (Reset),
        .load_i     (tmr_load),
        .load_val_i (gap_q),
        .tick_i     (tmr_tick),
        .expired_o  (tmr_exp)
    );

    // A paused pulse stays pending in the registers and is only masked here.
    assign En   = en_q & ~stall;
    assign Slt  = slt_q & ~stall;
    assign Busy = busy_q;
    assign Done = done_q;

endmodule

// File: tb/tb_event_gen.sv
// Scoreboard bench for event_gen: expected pulses/Done queued at Start, popped as seen.
module tb_event_gen;

    localparam int DIV = 4;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        Start = 1'b0;
    logic [31:0] Cnt0 = '0;
    logic [31:0] Cnt1 = '0;
    logic [7:0]  Gap = '0;
`ifdef EVENT_GEN_PAUSE_EN
    logic        Pause = 1'b0;
`endif
    logic        En, Slt, Busy, Done;

    typedef struct packed {
        logic [31:0] cyc;
        logic        en;
        logic        slt;
        logic        busy;
        logic        done;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;

    event_gen #(.CW(32), .GW(8), .DIV(DIV)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .Start (Start),
        .Cnt0  (Cnt0),
        .Cnt1  (Cnt1),
        .Gap   (Gap),
`ifdef EVENT_GEN_PAUSE_EN
        .Pause (Pause),
`endif
        .En    (En),
        .Slt   (Slt),
        .Busy  (Busy),
        .Done  (Done)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    // Every En or Done cycle must match the head of the expectation queue.
    always @(negedge Clk) begin
        ev_t obs, ex;
        if (Reset) begin
            if (En !== 1'b1) begin
                checks++;
                assert (Slt === 1'b0) else begin
                    errors++;
                    $error("FAIL slt_idle cyc=%0d obs=%b exp=0", cyc, Slt);
                end
            end
            if (En === 1'b1 || Done === 1'b1) begin
                obs = '{cyc: 32'(cyc), en: En, slt: Slt, busy: Busy, done: Done};
                checks++;
                assert (exp_q.size() > 0) else begin
                    errors++;
                    $error("FAIL unexpected_event obs=%h exp=none", obs);
                end
                if (exp_q.size() > 0) begin
                    ex = exp_q.pop_front();
                    checks++;
                    assert (obs === ex) else begin
                        errors++;
                        $error("FAIL event obs(cyc/en/slt/busy/done)=%0d/%b%b%b%b exp=%0d/%b%b%b%b",
                               obs.cyc, obs.en, obs.slt, obs.busy, obs.done,
                               ex.cyc, ex.en, ex.slt, ex.busy, ex.done);
                    end
                end
            end
        end
    end

    task automatic chk(input string tag, input logic obs, input logic exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s obs=%b exp=%b", tag, obs, exp_v);
        end
    endtask

    task automatic push_ev(input int c, input logic en, input logic slt,
                           input logic busy, input logic done);
        exp_q.push_back('{cyc: 32'(c), en: en, slt: slt, busy: busy, done: done});
    endtask

    // Start held for one cycle t; expectations derive from the timing formulae.
    task automatic start_cmd(input int c0, input int c1, input int g);
        int t, n;
        @(posedge Clk); #1;
        Start = 1'b1; Cnt0 = 32'(c0); Cnt1 = 32'(c1); Gap = 8'(g);
        t = cyc;
        n = c0 + DIV * c1;
        for (int k = 0; k < n; k++)
            push_ev(t + 1 + k * (g + 1), 1'b1, (k >= c0), 1'b1, 1'b0);
        push_ev((n == 0) ? t + 1 : t + 1 + (n - 1) * (g + 1) + 1, 1'b0, 1'b0, 1'b0, 1'b1);
        @(posedge Clk); #1;
        Start = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(posedge Clk);
            n++;
        end
        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL %s timeout pending=%0d exp=0", tag, exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(posedge Clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge Clk);
        #1;
        chk("rst_en", En, 1'b0);
        chk("rst_slt", Slt, 1'b0);
        chk("rst_busy", Busy, 1'b0);
        chk("rst_done", Done, 1'b0);
        Reset = 1'b1;
        repeat (2) @(posedge Clk);
        #1;

        start_cmd(3, 0, 0); wait_drain("c0_only");
        start_cmd(0, 2, 1); wait_drain("c1_div_gap1");
        start_cmd(2, 1, 2); wait_drain("mixed_gap2");
        start_cmd(0, 0, 0); wait_drain("zero");
        start_cmd(1, 1, 0); wait_drain("boundary_gap0");

        // Start during Busy must not disturb the run in progress.
        start_cmd(5, 0, 0);
        chk("busy_mid", Busy, 1'b1);
        @(posedge Clk); #1;
        Start = 1'b1; Cnt0 = 32'd3; Cnt1 = 32'd7; Gap = 8'd9;
        @(posedge Clk); #1;
        Start = 1'b0;
        wait_drain("ignored_start");

        // Start in the Done cycle is accepted.
        start_cmd(1, 0, 0);
        start_cmd(2, 0, 0);
        wait_drain("start_in_done");

        // Reset during the second of six pulses.
        start_cmd(6, 0, 1);
        @(posedge Clk);
        @(posedge Clk);
        #6;
        Reset = 1'b0;
        #1;
        chk("abort_en", En, 1'b0);
        chk("abort_busy", Busy, 1'b0);
        chk("abort_done", Done, 1'b0);
        exp_q.delete();
        repeat (3) @(posedge Clk);
        #1;
        Reset = 1'b1;
        repeat (3) @(posedge Clk);
        start_cmd(1, 0, 0); wait_drain("after_reset");

`ifdef EVENT_GEN_PAUSE_EN
        begin
            int t;
            @(posedge Clk); #1;
            Start = 1'b1; Cnt0 = 32'd3; Cnt1 = 32'd0; Gap = 8'd0;
            t = cyc;
            push_ev(t + 1, 1'b1, 1'b0, 1'b1, 1'b0);
            push_ev(t + 5, 1'b1, 1'b0, 1'b1, 1'b0);
            push_ev(t + 6, 1'b1, 1'b0, 1'b1, 1'b0);
            push_ev(t + 7, 1'b0, 1'b0, 1'b0, 1'b1);
            @(posedge Clk); #1;
            Start = 1'b0;
            @(posedge Clk); #1;
            Pause = 1'b1;
            chk("pause_busy", Busy, 1'b1);
            repeat (3) @(posedge Clk);
            #1;
            Pause = 1'b0;
            wait_drain("pause");
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
